// File: rtl/dirshade_merge.sv
// Lane router and round-robin merge for the direct-shading unit. Per-lane fixed delay
// lines keep payloads aligned with the shading pipeline; credits guarantee FIFO room.
module dirshade_merge #(
  parameter int                  DATA_W     = 64,
  parameter int                  NUM_CH     = 3,
  parameter logic [NUM_CH*8-1:0] LAT_VEC    = {8'd99, 8'd5, 8'd1},
  parameter int                  FIFO_DEPTH = 8,
  parameter bit                  PHASED     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v0,
  input  logic              us_valid,
  input  logic [2:0]        us_ch,
  input  logic [DATA_W-1:0] us_data,
  output logic              us_stall,
  output logic              ds_valid,
  output logic [2:0]        ds_ch,
  output logic [DATA_W-1:0] ds_data,
  input  logic              ds_stall,
  output logic [7:0]        drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_CH-1:0] lane_acc, lane_pop, lane_ne, lane_full;
  logic [DATA_W-1:0] lane_head [NUM_CH];
  logic              ch_ok, sel_full, accept, drop;
  logic [2:0]        rr, rr_pick, grant, lock_ch;
  logic              rr_found, locked;

  always_comb begin
    ch_ok    = 1'b0;
    sel_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (us_ch == 3'(i)) begin
        ch_ok    = 1'b1;
        sel_full = lane_full[i];
      end
    end
  end

  assign us_stall = rst | (us_valid & ((PHASED & ~v0) | (ch_ok & sel_full)));
  assign accept   = us_valid & ~us_stall;
  assign drop     = accept & ~ch_ok;

  always_comb begin
    lane_acc = '0;
    lane_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_acc[i] = accept & (us_ch == 3'(i));
      lane_pop[i] = ds_valid & ~ds_stall & (grant == 3'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam int LAT = int'(LAT_VEC[8*i +: 8]);

    logic [LAT-1:0]    dl_vld;
    logic [DATA_W-1:0] dl_data [LAT];
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     occ, inflight;
    logic              wr_en;

    assign wr_en        = dl_vld[LAT-1];
    assign lane_ne[i]   = (occ != '0);
    assign lane_full[i] = ((occ + inflight) == CW'(FIFO_DEPTH));
    assign lane_head[i] = mem[rd_ptr];

    // delay line: stage 0 loads on accept, last stage writes the FIFO
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dl_vld <= '0;
      end else begin
        dl_vld[0] <= lane_acc[i];
        for (int s = 1; s < LAT; s++) dl_vld[s] <= dl_vld[s-1];
      end
    end

    always_ff @(posedge clk) begin
      dl_data[0] <= us_data;
      for (int s = 1; s < LAT; s++) dl_data[s] <= dl_data[s-1];
    end

    // lane FIFO and credit bookkeeping
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= dl_data[LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
        inflight <= '0;
      end else begin
        assert (!(wr_en && !lane_pop[i] && occ == CW'(FIFO_DEPTH)));
        if (wr_en)       wr_ptr <= wr_ptr + AW'(1);
        if (lane_pop[i]) rd_ptr <= rd_ptr + AW'(1);
        case ({wr_en, lane_pop[i]})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: ;
        endcase
        case ({lane_acc[i], wr_en})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // merge: first non-empty lane at or after rr, frozen while the consumer stalls
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rr_found && lane_ne[i] && (3'(i) >= rr)) begin
        rr_found = 1'b1;
        rr_pick  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rr_found && lane_ne[i]) begin
        rr_found = 1'b1;
        rr_pick  = 3'(i);
      end
    end
    grant = locked ? lock_ch : rr_pick;
  end

  always_comb begin
    ds_valid = |lane_ne;
    ds_ch    = ds_valid ? grant : 3'd0;
    ds_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ds_valid && grant == 3'(i)) ds_data = lane_head[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= '0;
      locked   <= 1'b0;
      lock_ch  <= '0;
      drop_cnt <= '0;
    end else begin
      if (ds_valid && !ds_stall) begin
        rr     <= (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;
        locked <= 1'b0;
      end else if (ds_valid) begin
        locked  <= 1'b1;
        lock_ch <= grant;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dirshade_merge.sv
// Scoreboard bench for dirshade_merge: 3 lanes, latencies {99,5,1}, 4-entry FIFOs, phased input.
module tb_dirshade_merge;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b1;
  logic          us_valid = 1'b0;
  logic [2:0]    us_ch = 3'd0;
  logic [DW-1:0] us_data = '0;
  logic          ds_stall = 1'b0;
  logic          us_stall, ds_valid;
  logic [2:0]    ds_ch;
  logic [DW-1:0] ds_data;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  dirshade_merge #(
    .DATA_W(DW), .NUM_CH(3), .LAT_VEC({8'd99, 8'd5, 8'd1}), .FIFO_DEPTH(4), .PHASED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .v0(v0), .us_valid(us_valid), .us_ch(us_ch), .us_data(us_data),
    .us_stall(us_stall), .ds_valid(ds_valid), .ds_ch(ds_ch), .ds_data(ds_data),
    .ds_stall(ds_stall), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [1:0] ch);
    case (ch)
      2'd0:    return 1;
      2'd1:    return 5;
      default: return 99;
    endcase
  endfunction

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    int            rdy;
  } item_t;

  item_t      sbq[$];
  item_t      it;
  logic [1:0] m_rr = 2'd0;
  logic [1:0] m_lock_ch = 2'd0;
  bit         m_lock = 1'b0;
  int         m_drop = 0;
  int         cyc = 0;
  int         cnt [4];
  int         hidx [4];
  bit         ne [4];
  logic [1:0] g, c;
  bit         found, ev, es;

  // reference model, evaluated mid-cycle on registered state and held inputs
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ds_valid", 64'(ds_valid), 64'd0);
      check("rst_ds_ch", 64'(ds_ch), 64'd0);
      check("rst_ds_data", ds_data, 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("rst_us_stall", 64'(us_stall), 64'd1);
      sbq.delete();
      m_rr = 2'd0; m_lock = 1'b0; m_lock_ch = 2'd0; m_drop = 0;
    end else begin
      cyc++;
      for (int k = 0; k < 4; k++) begin cnt[k] = 0; hidx[k] = -1; ne[k] = 1'b0; end
      for (int j = 0; j < sbq.size(); j++) begin
        c = sbq[j].ch;
        cnt[c]++;
        if (hidx[c] < 0) begin hidx[c] = j; ne[c] = (sbq[j].rdy <= cyc); end
      end
      found = 1'b0; g = 2'd0;
      for (int k = 0; k < 3; k++) begin
        c = 2'((int'(m_rr) + k) % 3);
        if (!found && ne[c]) begin found = 1'b1; g = c; end
      end
      if (m_lock) g = m_lock_ch;
      ev = ne[0] | ne[1] | ne[2];
      check("ds_valid", 64'(ds_valid), 64'(ev));
      if (ev && hidx[g] >= 0) begin
        check("ds_ch", 64'(ds_ch), 64'(g));
        check("ds_data", ds_data, sbq[hidx[g]].d);
      end
      es = us_valid && (!v0 || (us_ch < 3'd3 && cnt[us_ch[1:0]] == 4));
      check("us_stall", 64'(us_stall), 64'(es));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (ev && !ds_stall) begin
        sbq.delete(hidx[g]);
        m_rr = (g == 2'd2) ? 2'd0 : g + 2'd1;
        m_lock = 1'b0;
      end else if (ev) begin
        m_lock = 1'b1; m_lock_ch = g;
      end
      if (us_valid && !es) begin
        if (us_ch < 3'd3) begin
          it.ch = us_ch[1:0]; it.d = us_data; it.rdy = cyc + 1 + lat_of(us_ch[1:0]);
          sbq.push_back(it);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] ch, input logic [DW-1:0] d);
    us_valid = 1'b1; us_ch = ch; us_data = d;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!us_stall) begin
        @(posedge clk); #1;
        us_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd1, 64'd0);
    us_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    bit seen, got;
    tick(3);
    rst = 1'b0;

    // single item on lane 1
    send(3'd1, 64'hA5);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); n++; seen = ds_valid; end
    check("single_lat", 64'(n), 64'd6);
    check("single_data", ds_data, 64'hA5);
    check("single_ch", 64'(ds_ch), 64'd1);
    @(negedge clk);
    check("single_once", 64'(ds_valid), 64'd0);
    tick(5);

    // credit exhaustion on lane 2
    ds_stall = 1'b1;
    for (int k = 0; k < 4; k++) send(3'd2, 64'h200 + 64'(k));
    us_valid = 1'b1; us_ch = 3'd2; us_data = 64'h204;
    @(negedge clk);
    check("cred_stall", 64'(us_stall), 64'd1);
    tick(105);
    ds_stall = 1'b0;
    @(negedge clk);
    check("cred_hold", 64'(us_stall), 64'd1);
    @(negedge clk);
    check("cred_free", 64'(us_stall), 64'd0);
    @(posedge clk); #1;
    us_valid = 1'b0;
    tick(110);

    // fairness: three items per lane
    ds_stall = 1'b1;
    for (int k = 0; k < 3; k++) send(3'd2, 64'h320 + 64'(k));
    for (int k = 0; k < 3; k++) send(3'd1, 64'h310 + 64'(k));
    for (int k = 0; k < 3; k++) send(3'd0, 64'h300 + 64'(k));
    tick(105);
    ds_stall = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("fair_ch", 64'(ds_ch), 64'(k % 3));
    end
    tick(5);

    // stall stability with a lower-priority arrival and a would-be preemptor
    send(3'd0, 64'h400);
    tick(4);
    ds_stall = 1'b1;
    send(3'd2, 64'h4A0);
    send(3'd2, 64'h4B0);
    tick(102);
    send(3'd0, 64'h4C0);
    send(3'd1, 64'h4D0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stab_ch", 64'(ds_ch), 64'd2);
      check("stab_data", ds_data, 64'h4A0);
    end
    tick(1);
    ds_stall = 1'b0;
    tick(10);

    // phased acceptance, v0 one cycle in three
    us_valid = 1'b1; us_ch = 3'd0; us_data = 64'h500;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      v0 = (k % 3 == 0);
      @(negedge clk);
      got = !us_stall;
      @(posedge clk); #1;
      if (got) begin acc++; us_data = us_data + 64'd1; end
    end
    us_valid = 1'b0; v0 = 1'b1;
    check("phase_acc", 64'(acc), 64'd4);
    tick(5);

    // out-of-range lane drops
    send(3'd5, 64'hDEAD);
    check("drop_one", 64'(drop_cnt), 64'd1);
    us_valid = 1'b1; us_ch = 3'd5;
    tick(299);
    us_valid = 1'b0;
    check("drop_sat", 64'(drop_cnt), 64'd255);
    tick(3);

    // asynchronous reset with six items in flight
    ds_stall = 1'b1;
    send(3'd2, 64'h6A); send(3'd2, 64'h6B);
    send(3'd1, 64'h6C); send(3'd1, 64'h6D);
    send(3'd0, 64'h6E); send(3'd0, 64'h6F);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(ds_valid), 64'd0);
    check("arst_stall", 64'(us_stall), 64'd1);
    check("arst_drop", 64'(drop_cnt), 64'd0);
    tick(2);
    rst = 1'b0;
    ds_stall = 1'b0;
    send(3'd0, 64'h600D);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); n++; seen = ds_valid; end
    check("rst_lat", 64'(n), 64'd2);
    check("rst_data", ds_data, 64'h600D);
    acc = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ds_valid) acc++;
    end
    check("rst_stray", 64'(acc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
